// File: rtl/fmesh_route_stage.sv
// rtl/fmesh_route_stage.sv - look-ahead route stage with 2-entry skid pipeline
// Optional destination address check: define FMESH_ROUTE_ADDR_CHECK_EN.
module fmesh_route_stage #(
    parameter int    NX         = 4,
    parameter int    NY         = 4,
    parameter int    NL         = 1,
    parameter int    EAw        = 9,
    parameter string ROUTE_TYPE = "DETERMINISTIC",
    parameter int    Fpay       = 32,
    parameter int    PLw        = 4,
    localparam int   EXw        = $clog2(NX),
    localparam int   EYw        = $clog2(NY),
    localparam int   EPw        = EAw - EXw - EYw
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [EXw-1:0]   current_x,
    input  logic [EYw-1:0]   current_y,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_hdr,
    input  logic             in_tail,
    input  logic [EAw-1:0]   in_dest_e_addr,
    input  logic [Fpay-1:0]  in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hdr,
    output logic             out_tail,
    output logic [Fpay-1:0]  out_payload,
    output logic [3:0]       dest_port_coded,
    output logic [PLw-1:0]   endp_localp_num,
    output logic             addr_err
);
    localparam bit ADAPTIVE = (ROUTE_TYPE == "FULL_ADAPTIVE");
    // entry layout: {err, localp, route, hdr, tail, payload}
    localparam int EW = 3 + 4 + PLw + Fpay;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PKT  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [3:0]     lat_route_q, lat_route_d;
    logic [PLw-1:0] lat_lp_q, lat_lp_d;
    logic [EW-1:0]  out_q, out_d, skid_q, skid_d, in_ent;
    logic           out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q;

    logic [EXw-1:0] dx;
    logic [EYw-1:0] dy;
    logic [EPw-1:0] ep;
    logic           head_bad, idle_err, accept, drain;
    logic [3:0]     head_route, ent_route;
    logic [PLw-1:0] head_lp, ent_lp;
    logic           ent_err;

    assign dx = in_dest_e_addr[EXw-1:0];
    assign dy = in_dest_e_addr[EXw +: EYw];
    assign ep = in_dest_e_addr[EAw-1 -: EPw];

`ifdef FMESH_ROUTE_ADDR_CHECK_EN
    assign head_bad = (int'(dx) > NX - 1) || (int'(dy) > NY - 1) || (int'(ep) > 4 + NL - 1);
    assign idle_err = 1'b1;
`else
    assign head_bad = 1'b0;
    assign idle_err = 1'b0;
`endif

    assign accept = in_valid & rdy_q;
    assign drain  = out_vld_q & out_ready;

    always_comb begin
        head_route = 4'b0000;
        head_lp    = '0;
        if (!head_bad) begin
            head_route[3] = (dx > current_x);
            head_route[2] = (dy < current_y);
            head_route[1] = (dx != current_x);
            head_route[0] = ADAPTIVE ? (dy != current_y)
                                     : ((dx == current_x) && (dy != current_y));
            head_lp       = PLw'(ep);
        end
    end

    // Packet FSM: heads always re-route, so a lost tail cannot leave a stale route behind.
    always_comb begin
        state_d     = state_q;
        lat_route_d = lat_route_q;
        lat_lp_d    = lat_lp_q;
        ent_route   = 4'b0000;
        ent_lp      = '0;
        ent_err     = 1'b0;
        if (in_hdr) begin
            ent_route = head_route;
            ent_lp    = head_lp;
            ent_err   = head_bad;
        end else if (state_q == S_PKT) begin
            ent_route = lat_route_q;
            ent_lp    = lat_lp_q;
        end else begin
            ent_err   = idle_err;
        end
        if (accept) begin
            if (in_hdr) begin
                lat_route_d = head_route;
                lat_lp_d    = head_lp;
                state_d     = in_tail ? S_IDLE : S_PKT;
            end else if (in_tail) begin
                state_d = S_IDLE;
            end
        end
    end

    assign in_ent = {ent_err, ent_lp, ent_route, in_hdr, in_tail, in_payload};

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || drain) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = in_ent;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_route_q <= 4'b0000;
            lat_lp_q    <= '0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_route_q <= lat_route_d;
            lat_lp_q    <= lat_lp_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            rdy_q       <= ~skid_vld_d;
        end
    end

    assign in_ready        = rdy_q;
    assign out_valid       = out_vld_q;
    assign out_payload     = out_q[Fpay-1:0];
    assign out_tail        = out_q[Fpay];
    assign out_hdr         = out_q[Fpay+1];
    assign dest_port_coded = out_q[Fpay+2 +: 4];
    assign endp_localp_num = out_q[Fpay+6 +: PLw];
    assign addr_err        = out_q[EW-1];
endmodule

// File: tb/tb_fmesh_route_stage.sv
// tb/tb_fmesh_route_stage.sv - scoreboard bench for fmesh_route_stage (XY and adaptive)
module tb_fmesh_route_stage;
    localparam int CX = 1;
    localparam int CY = 2;
    localparam int NL = 2;
`ifdef FMESH_ROUTE_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  current_x = 2'(CX);
    logic [1:0]  current_y = 2'(CY);
    logic        in_valid = 1'b0, in_hdr = 1'b0, in_tail = 1'b0;
    logic [8:0]  in_dest_e_addr = '0;
    logic [31:0] in_payload = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_hdr, out_tail, addr_err;
    logic [31:0] out_payload;
    logic [3:0]  dest_port_coded, endp_localp_num;
    logic        a_in_ready, a_out_valid, a_out_hdr, a_out_tail, a_addr_err;
    logic [31:0] a_out_payload;
    logic [3:0]  a_dest_port_coded, a_endp_localp_num;

    fmesh_route_stage #(.NL(NL)) dut (
        .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr), .in_tail(in_tail),
        .in_dest_e_addr(in_dest_e_addr), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr), .out_tail(out_tail),
        .out_payload(out_payload), .dest_port_coded(dest_port_coded),
        .endp_localp_num(endp_localp_num), .addr_err(addr_err));

    fmesh_route_stage #(.NL(NL), .ROUTE_TYPE("FULL_ADAPTIVE")) dut_ad (
        .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_hdr(in_hdr), .in_tail(in_tail),
        .in_dest_e_addr(in_dest_e_addr), .in_payload(in_payload),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_hdr(a_out_hdr), .out_tail(a_out_tail),
        .out_payload(a_out_payload), .dest_port_coded(a_dest_port_coded),
        .endp_localp_num(a_endp_localp_num), .addr_err(a_addr_err));

    always #5 clk = ~clk;

    typedef struct {
        logic        hdr, tail, err;
        logic [31:0] pay;
        logic [3:0]  rd, ra, lp;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;
    bit m_pkt = 1'b0;
    logic [3:0] m_rd = '0, m_ra = '0, m_lp = '0;
    bit rnd_done;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mroute(int ex, int ey, bit adapt);
        logic [3:0] r;
        r[3] = ex > CX;
        r[2] = ey < CY;
        r[1] = ex != CX;
        r[0] = adapt ? (ey != CY) : ((ex == CX) && (ey != CY));
        return r;
    endfunction

    task automatic model_push(bit h, bit t, int ex, int ey, int ep, logic [31:0] pay);
        exp_t e;
        bit   bad_addr;
        e.hdr = h; e.tail = t; e.pay = pay;
        if (h) begin
            bad_addr = CHK && (ep > 4 + NL - 1);
            e.err = bad_addr;
            e.rd  = bad_addr ? 4'b0 : mroute(ex, ey, 1'b0);
            e.ra  = bad_addr ? 4'b0 : mroute(ex, ey, 1'b1);
            e.lp  = bad_addr ? 4'b0 : 4'(ep);
            m_rd = e.rd; m_ra = e.ra; m_lp = e.lp;
            m_pkt = !t;
        end else if (m_pkt) begin
            e.err = 1'b0; e.rd = m_rd; e.ra = m_ra; e.lp = m_lp;
            if (t) m_pkt = 1'b0;
        end else begin
            e.err = CHK; e.rd = 4'b0; e.ra = 4'b0; e.lp = 4'b0;
        end
        sb.push_back(e);
    endtask

    task automatic send(bit h, bit t, int ex, int ey, int ep, logic [31:0] pay);
        int n = 0;
        in_valid = 1'b1; in_hdr = h; in_tail = t; in_payload = pay;
        in_dest_e_addr = 9'(ep * 16 + ey * 4 + ex);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        else model_push(h, t, ex, ey, ep, pay);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_hdr = 1'b0; in_tail = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hdr", out_hdr, e.hdr);
                chk("tail", out_tail, e.tail);
                chk("payload", out_payload, e.pay);
                chk("route_xy", dest_port_coded, e.rd);
                chk("localp", endp_localp_num, e.lp);
                chk("addr_err", addr_err, e.err);
                chk("ad_valid", a_out_valid, 1);
                chk("route_adaptive", a_dest_port_coded, e.ra);
                chk("ad_payload", a_out_payload, e.pay);
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_route", {out_hdr, out_tail, dest_port_coded, endp_localp_num, addr_err}, 0);
        chk("rst_payload", out_payload, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        out_ready = 1'b1;
        send(1, 1, 3, 2, 0, 32'hA0);
        send(1, 1, 1, 0, 0, 32'hA1);
        send(1, 1, 1, 2, 5, 32'hA2);
        send(1, 1, 0, 3, 0, 32'hA3);
        send(1, 1, 3, 1, 7, 32'hA4);
        send(0, 0, 2, 2, 1, 32'hA5);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // 4-flit packet against a stalled output
        out_ready = 1'b0;
        fork
            begin
                send(1, 0, 0, 0, 3, 32'hB0);
                send(0, 0, 3, 3, 1, 32'hB1);
                send(0, 0, 3, 3, 1, 32'hB2);
                send(0, 1, 3, 3, 1, 32'hB3);
                idle();
            end
            begin
                @(posedge clk); @(posedge clk); #1;
                chk("skid_full_in_ready", in_ready, 0);
                chk("skid_full_out_valid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        send(0, 1, 2, 1, 0, 32'hB4);
        idle();

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 7), 32'hC000 + 32'(i));
                idle();
                rnd_done = 1'b1;
            end
            begin
                n = 0;
                while (!rnd_done && n < 2000) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                    n++;
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_random", sb.size(), 0);

        // reset mid-packet with both entries holding flits
        out_ready = 1'b0;
        send(1, 0, 3, 0, 2, 32'hD0);
        send(0, 0, 3, 0, 2, 32'hD1);
        idle();
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        sb.delete();
        m_pkt = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready_back", in_ready, 1);
        send(0, 1, 3, 0, 2, 32'hE0);
        send(1, 1, 2, 3, 1, 32'hE1);
        idle();
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_final", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("final_out_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fmesh_route_stage.md
Name: fmesh_route_stage

Overview:
- Registered look-ahead route-computation stage for fmesh routers.
- Sits between an input-port flit buffer and the fmesh destination-port decoder.
- Head flits: decodes the destination endpoint address against the current router coordinates and produces a 4-bit coded destination port {x,y,a,b} plus the endpoint local-port number.
- Carries the route for all flits of the packet through a 2-entry valid/ready pipeline with skid buffering.

Parameters:
- NX, 4, routers in x.
- NY, 4, routers in y.
- NL, 1, local endpoints per router.
- EAw, 9, endpoint address width; layout {ep,ey,ex} with EXw=log2(NX), EYw=log2(NY), EPw=EAw-EXw-EYw.
- ROUTE_TYPE, "DETERMINISTIC", "DETERMINISTIC" (XY) or "FULL_ADAPTIVE".
- Fpay, 32, flit payload width carried unmodified.
- PLw, 4, local-port-number width; must be >= log2(4+NL).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- current_x  in  EXw  this router's x coordinate; static.
- current_y  in  EYw  this router's y coordinate; static.
- in_valid  in  1  input flit valid.
- in_ready  out  1  stage can accept a flit.
- in_hdr  in  1  head flit.
- in_tail  in  1  tail flit; single-flit packet when in_hdr and in_tail are both set.
- in_dest_e_addr  in  EAw  destination endpoint address; sampled on head only.
- in_payload  in  Fpay  flit payload.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts.
- out_hdr, out_tail  out  1 each  registered flags.
- out_payload  out  Fpay  registered payload.
- dest_port_coded  out  4  {x,y,a,b} route of the current packet.
- endp_localp_num  out  PLw  destination port index at the destination router.
- addr_err  out  1  see Optional Feature.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: out_valid=0, out_hdr=0, out_tail=0, out_payload=0, dest_port_coded=0, endp_localp_num=0, addr_err=0, both skid entries empty, in_ready=1 once reset deasserts.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = skid entry empty; it is a registered signal, with no combinational path from out_ready.
- Latency:
  - 1 cycle from input transfer to out_valid when the output register is free.
  - Back-to-back throughput is 1 flit/clk while out_ready=1.
- Skid buffer:
  - Output register stalled (out_valid & ~out_ready) and a flit arrives: the flit goes to the skid entry and in_ready drops the next cycle.
  - Output drains: the skid entry moves to the output register.
  - Simultaneous drain and arrive with an empty skid: the new flit loads the output register directly.
  - Flit order is always preserved.
- Route computation (head flits only; combinational from in_dest_e_addr, registered with the flit):
  - dx = ex, dy = ey.
  - x = (dx > current_x), so x=1 means EAST.
  - y = (dy < current_y), so y=1 means NORTH; y index increases southward.
  - DETERMINISTIC: a = (dx != current_x); b = (dx == current_x) & (dy != current_y).
  - FULL_ADAPTIVE: a = (dx != current_x); b = (dy != current_y).
  - endp_localp_num = ep, zero-extended to PLw.
  - a=b=0 means the packet ejects at this router via port ep. Ports 0 and 1..4 are local/edge; 5.. are extra locals.
- Packet state FSM, on the input side:
  - IDLE: accepts only head flits. A head without tail latches the route and moves to IN_PKT. A head with tail stays IDLE.
  - IN_PKT: body/tail flits are tagged with the latched route. Tail returns to IDLE.
  - A head arriving in IN_PKT overwrites the route (tail was lost) and stays IN_PKT.
  - A non-head flit in IDLE passes with route 0 and addr_err behaviour per macro.
- Route tagging: each skid and output entry stores its own route copy. Output route fields therefore always correspond to the flit on out_payload.
- Reset mid-packet: all entries are discarded and the FSM returns to IDLE.

Optional Feature:
- Macro: FMESH_ROUTE_ADDR_CHECK_EN.
- Defined:
  - Head flits are validity-checked: ex <= NX-1, ey <= NY-1, ep <= 4+NL-1.
  - Invalid heads, and non-head flits received in IDLE, set the entry's addr_err flag; addr_err is presented with the flit.
  - Route is forced to {0,0,0,0} and endp_localp_num to 0, so the flit goes to local port 0.
- Undefined: no check logic; addr_err tied 0; the route is computed from the raw fields.

Test Plan:
- NX=NY=4, current (1,2), DETERMINISTIC; single-flit head with dest ex=3, ey=2, ep=0, out_ready=1 -> next cycle out_valid=1, dest_port_coded=4'b1010, endp_localp_num=0.
- Same setup, dest ex=1, ey=0, ep=0 -> 4'b0101 (NORTH). Dest ex=1, ey=2, ep=5 with NL=2 -> 4'b0000, endp_localp_num=5.
- FULL_ADAPTIVE, current (1,2), dest (0,3) -> 4'b0011; DETERMINISTIC with the same dest -> 4'b0010.
- 4-flit packet, out_ready held 0 for 3 cycles after the first flit -> in_ready=0 after the skid fills; no loss or duplication; all 4 outputs carry the head's route; tail returns the FSM to IDLE.
- Assert reset for 1 cycle mid-packet with both entries full -> out_valid=0 and in_ready=0 asynchronously; next head routed correctly with no stale route.
- With FMESH_ROUTE_ADDR_CHECK_EN, NX=4, head with ex=3, ep=7, NL=1 -> addr_err=1, dest_port_coded=0; without the macro, addr_err=0.
